// File: rtl/spi_link.sv
// spi_link: oversampled SPI slave (mode 0) with a command FIFO for received
// words, a return FIFO feeding MISO, and sticky error flags.
module spi_link #(
    parameter int unsigned       WORD_W    = 8,
    parameter int unsigned       CMD_DEPTH = 4,
    parameter int unsigned       RET_DEPTH = 4,
    parameter logic              CS_ACTIVE = 1'b1,
    parameter logic [WORD_W-1:0] FILL      = {WORD_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_clk,
    input  logic              spi_cs,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [WORD_W-1:0] command_data,
    output logic              command_valid,
    input  logic              command_ready,
    input  logic [WORD_W-1:0] return_data,
    input  logic              return_push,
    output logic              return_full,
    output logic              rx_overflow,
    output logic              tx_underflow,
    output logic              frame_abort,
    input  logic              status_clear
);

    localparam int unsigned BW  = (WORD_W > 2) ? $clog2(WORD_W) : 1;
    localparam int unsigned CAW = $clog2(CMD_DEPTH);
    localparam int unsigned RAW = $clog2(RET_DEPTH);
    localparam int unsigned CPW = CAW + 1;
    localparam int unsigned RPW = RAW + 1;

    // After reset the synchronisers need three cycles before cs_act reflects
    // the pin; a CS already active then is treated as a frame already in
    // progress and ignored until it goes inactive.
    typedef enum logic [2:0] {
        ST_FILL0,
        ST_FILL1,
        ST_FILL2,
        ST_BLOCKED,
        ST_IDLE,
        ST_FRAME
    } state_e;

    state_e state_q, state_d;

    logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic cs_meta_q, cs_sync_q;
    logic mosi_meta_q, mosi_sync_q;

    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] rx_shift_q, rx_shift_d;
    logic [WORD_W-1:0] tx_shift_q, tx_shift_d;
    logic              load_pend_q, load_pend_d;
    logic              rx_overflow_q, rx_overflow_d;
    logic              tx_underflow_q, tx_underflow_d;
    logic              frame_abort_q, frame_abort_d;

    logic [WORD_W-1:0] cmd_mem_q [CMD_DEPTH];
    logic [CPW-1:0]    cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
    logic [WORD_W-1:0] ret_mem_q [RET_DEPTH];
    logic [RPW-1:0]    ret_wr_q, ret_wr_d, ret_rd_q, ret_rd_d;

    logic cs_act, sclk_rise, sclk_fall;
    logic frame_start, frame_end;
    logic in_frame, rx_rise, tx_fall, word_done;
    logic [WORD_W-1:0] rx_word;
    logic cmd_full, cmd_empty, cmd_pop, cmd_push, rx_drop;
    logic ret_full, ret_empty, ret_pop, ret_wr, tx_load;

    // Two-flop synchronisers plus an edge-detect flop on spi_clk
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            cs_meta_q   <= ~CS_ACTIVE;
            cs_sync_q   <= ~CS_ACTIVE;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            sclk_meta_q <= spi_clk;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            cs_meta_q   <= spi_cs;
            cs_sync_q   <= cs_meta_q;
            mosi_meta_q <= spi_mosi;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    assign cs_act    = (cs_sync_q == CS_ACTIVE);
    assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
    assign sclk_fall = ~sclk_sync_q & sclk_prev_q;

    // Frame state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_FILL0;
        else        state_q <= state_d;
    end

    // Frame tracking: start on cs_act rising, end on cs_act falling
    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state_q)
            ST_FILL0:   state_d = ST_FILL1;
            ST_FILL1:   state_d = ST_FILL2;
            ST_FILL2:   state_d = cs_act ? ST_BLOCKED : ST_IDLE;
            ST_BLOCKED: if (!cs_act) state_d = ST_IDLE;
            ST_IDLE: begin
                if (cs_act) begin
                    state_d     = ST_FRAME;
                    frame_start = 1'b1;
                end
            end
            ST_FRAME: begin
                if (!cs_act) begin
                    state_d   = ST_IDLE;
                    frame_end = 1'b1;
                end
            end
            default:    state_d = ST_FILL0;
        endcase
    end

    assign in_frame  = (state_q == ST_FRAME) && cs_act;
    assign rx_rise   = in_frame & sclk_rise;
    assign tx_fall   = in_frame & sclk_fall;
    assign word_done = rx_rise && (bit_cnt_q == BW'(WORD_W - 1));
    assign rx_word   = {rx_shift_q[WORD_W-2:0], mosi_sync_q};

    assign cmd_empty = (cmd_wr_q == cmd_rd_q);
    assign cmd_full  = (cmd_wr_q[CAW] != cmd_rd_q[CAW]) &&
                       (cmd_wr_q[CAW-1:0] == cmd_rd_q[CAW-1:0]);
    assign cmd_pop   = ~cmd_empty & command_ready;
    assign cmd_push  = word_done & (~cmd_full | cmd_pop);
    assign rx_drop   = word_done & cmd_full & ~cmd_pop;

    assign ret_empty = (ret_wr_q == ret_rd_q);
    assign ret_full  = (ret_wr_q[RAW] != ret_rd_q[RAW]) &&
                       (ret_wr_q[RAW-1:0] == ret_rd_q[RAW-1:0]);
    assign tx_load   = frame_start | (tx_fall & load_pend_q);
    assign ret_pop   = tx_load & ~ret_empty;
    assign ret_wr    = return_push & ~ret_full;

    // Shift registers, bit counter, FIFO pointers and sticky flags
    always_comb begin
        bit_cnt_d      = bit_cnt_q;
        rx_shift_d     = rx_shift_q;
        tx_shift_d     = tx_shift_q;
        load_pend_d    = load_pend_q;
        cmd_wr_d       = cmd_wr_q;
        cmd_rd_d       = cmd_rd_q;
        ret_wr_d       = ret_wr_q;
        ret_rd_d       = ret_rd_q;
        rx_overflow_d  = rx_drop | (rx_overflow_q & ~status_clear);
        tx_underflow_d = (tx_load & ret_empty) | (tx_underflow_q & ~status_clear);
        frame_abort_d  = (frame_end && (bit_cnt_q != '0)) |
                         (frame_abort_q & ~status_clear);

        if (frame_end) begin
            bit_cnt_d   = '0;
            load_pend_d = 1'b0;
            tx_shift_d  = FILL;
        end else begin
            if (rx_rise) begin
                rx_shift_d = rx_word;
                bit_cnt_d  = word_done ? '0 : bit_cnt_q + BW'(1);
            end
            if (word_done) begin
                load_pend_d = 1'b1;
            end else if (tx_fall) begin
                load_pend_d = 1'b0;
            end
            if (tx_load) begin
                tx_shift_d = ret_empty ? FILL : ret_mem_q[ret_rd_q[RAW-1:0]];
            end else if (tx_fall) begin
                tx_shift_d = {tx_shift_q[WORD_W-2:0], 1'b0};
            end
        end

        if (cmd_push) cmd_wr_d = cmd_wr_q + CPW'(1);
        if (cmd_pop)  cmd_rd_d = cmd_rd_q + CPW'(1);
        if (ret_wr)   ret_wr_d = ret_wr_q + RPW'(1);
        if (ret_pop)  ret_rd_d = ret_rd_q + RPW'(1);
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt_q      <= '0;
            rx_shift_q     <= '0;
            tx_shift_q     <= FILL;
            load_pend_q    <= 1'b0;
            cmd_wr_q       <= '0;
            cmd_rd_q       <= '0;
            ret_wr_q       <= '0;
            ret_rd_q       <= '0;
            rx_overflow_q  <= 1'b0;
            tx_underflow_q <= 1'b0;
            frame_abort_q  <= 1'b0;
        end else begin
            bit_cnt_q      <= bit_cnt_d;
            rx_shift_q     <= rx_shift_d;
            tx_shift_q     <= tx_shift_d;
            load_pend_q    <= load_pend_d;
            cmd_wr_q       <= cmd_wr_d;
            cmd_rd_q       <= cmd_rd_d;
            ret_wr_q       <= ret_wr_d;
            ret_rd_q       <= ret_rd_d;
            rx_overflow_q  <= rx_overflow_d;
            tx_underflow_q <= tx_underflow_d;
            frame_abort_q  <= frame_abort_d;
        end
    end

    // Command FIFO storage
    always_ff @(posedge clk) begin
        if (cmd_push) cmd_mem_q[cmd_wr_q[CAW-1:0]] <= rx_word;
    end

    // Return FIFO storage
    always_ff @(posedge clk) begin
        if (ret_wr) ret_mem_q[ret_wr_q[RAW-1:0]] <= return_data;
    end

    assign command_data  = cmd_mem_q[cmd_rd_q[CAW-1:0]];
    assign command_valid = ~cmd_empty;
    assign return_full   = ret_full;
    assign spi_miso      = tx_shift_q[WORD_W-1];
    assign spi_miso_oe   = cs_act;
    assign rx_overflow   = rx_overflow_q;
    assign tx_underflow  = tx_underflow_q;
    assign frame_abort   = frame_abort_q;

endmodule
